load_store_multiple_sequencer: RTL and testbench

LOAD_STORE_MULTIPLE_SEQUENCER -- requirements
Module: load_store_multiple_sequencer

---
 rtl/load_store_multiple_sequencer_pkg.sv | 31 +++
 rtl/lsm_priority_encoder.sv | 22 ++
 rtl/load_store_multiple_sequencer.sv | 168 ++++++++++++++++
 tb/tb_load_store_multiple_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_multiple_sequencer_pkg.sv
// Shared encodings for the LDM/STM sequencer: FSM states, addressing modes,
// word stride and a register-list population count.
package load_store_multiple_sequencer_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LIST_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Encoded as {pre, up} so the request bits map straight onto a mode.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_IA = 2'b01,
        MODE_DB = 2'b10,
        MODE_IB = 2'b11
    } addr_mode_e;

    function automatic logic [4:0] popcount16(input logic [LIST_W-1:0] list);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < int'(LIST_W); i++) begin
            n = n + 5'(list[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lsm_priority_encoder.sv
// Lowest-set-bit finder over a 16-entry register list.
module lsm_priority_encoder
    import load_store_multiple_sequencer_pkg::*;
(
    input  logic [LIST_W-1:0] i_list,
    output logic [3:0]        o_idx,
    output logic              o_valid
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_list;
        for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
            if (i_list[i]) begin
                o_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/load_store_multiple_sequencer.sv
// LDM/STM sequencer: turns one block-transfer request into per-register memory
// beats followed by a single completion/writeback record.
module load_store_multiple_sequencer
    import load_store_multiple_sequencer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_load_in,
    input  logic              req_up_in,
    input  logic              req_pre_in,
    input  logic              req_wb_in,
    input  logic [ADDR_W-1:0] req_base_in,
    input  logic [3:0]        req_rn_addr_in,
    input  logic [15:0]       req_reg_list_in,
    input  logic [TAG_W-1:0]  req_tag_in,
    input  logic              mem_ready_in,
    output logic              mem_valid_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [3:0]        mem_rd_addr_out,
    output logic              mem_w_en_out,
    output logic              mem_last_out,
    output logic [TAG_W-1:0]  mem_tag_out,
    output logic              done_out,
    output logic              wb_en_out,
    output logic [3:0]        wb_rn_addr_out,
    output logic [ADDR_W-1:0] wb_data_out,
    output logic [TAG_W-1:0]  wb_tag_out
);

    state_e              r_state;
    logic [15:0]         r_list;
    logic                r_mem_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [3:0]          r_mem_rd_addr;
    logic                r_mem_w_en;
    logic                r_mem_last;
    logic [TAG_W-1:0]    r_tag;
    logic                r_done;
    logic                r_wb_en;
    logic                r_wb_pending;
    logic [3:0]          r_wb_rn;
    logic [ADDR_W-1:0]   r_wb_data;

    logic [15:0]         w_enc_list;
    logic [15:0]         w_rest;
    logic [3:0]          w_idx;
    logic                w_enc_valid;
    logic [4:0]          w_count;
    logic [ADDR_W-1:0]   w_span;
    logic [ADDR_W-1:0]   w_stride;
    logic [ADDR_W-1:0]   w_start;
    logic [ADDR_W-1:0]   w_wb_data;
    logic                w_wb_allowed;
    addr_mode_e          w_mode;

    // One encoder serves both the incoming list (first beat) and the remaining list.
    assign w_enc_list = (r_state == ST_IDLE) ? req_reg_list_in : r_list;
    assign w_rest     = w_enc_list & ~(16'(1) << w_idx);

    lsm_priority_encoder u_prio (
        .i_list  (w_enc_list),
        .o_idx   (w_idx),
        .o_valid (w_enc_valid)
    );

    assign w_count      = popcount16(req_reg_list_in);
    assign w_stride     = ADDR_W'(WORD_BYTES);
    assign w_span       = ADDR_W'(w_count) * w_stride;
    assign w_mode       = addr_mode_e'({req_pre_in, req_up_in});
    assign w_wb_data    = req_up_in ? (req_base_in + w_span) : (req_base_in - w_span);
    assign w_wb_allowed = req_wb_in & ~(req_load_in & req_reg_list_in[req_rn_addr_in]);

    always_comb begin
        w_start = req_base_in;
        case (w_mode)
            MODE_IA: w_start = req_base_in;
            MODE_IB: w_start = req_base_in + w_stride;
            MODE_DA: w_start = req_base_in - w_span + w_stride;
            MODE_DB: w_start = req_base_in - w_span;
            default: w_start = req_base_in;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state       <= ST_IDLE;
            r_list        <= '0;
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_rd_addr <= '0;
            r_mem_w_en    <= 1'b0;
            r_mem_last    <= 1'b0;
            r_tag         <= '0;
            r_done        <= 1'b0;
            r_wb_en       <= 1'b0;
            r_wb_pending  <= 1'b0;
            r_wb_rn       <= '0;
            r_wb_data     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_in) begin
                        r_tag        <= req_tag_in;
                        r_mem_w_en   <= ~req_load_in;
                        r_wb_pending <= w_wb_allowed;
                        r_wb_rn      <= req_rn_addr_in;
                        r_wb_data    <= w_wb_data;
                        if (w_enc_valid) begin
                            r_state       <= ST_ISSUE;
                            r_mem_valid   <= 1'b1;
                            r_mem_addr    <= w_start;
                            r_mem_rd_addr <= w_idx;
                            r_mem_last    <= (w_rest == '0);
                            r_list        <= w_rest;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_wb_en <= w_wb_allowed;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_mem_valid && mem_ready_in) begin
                        if (r_mem_last) begin
                            r_state     <= ST_DONE;
                            r_mem_valid <= 1'b0;
                            r_mem_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_wb_en     <= r_wb_pending;
                        end else begin
                            r_mem_addr    <= r_mem_addr + w_stride;
                            r_mem_rd_addr <= w_idx;
                            r_mem_last    <= (w_rest == '0);
                            r_list        <= w_rest;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_wb_en <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_out   = (r_state == ST_IDLE);
    assign mem_valid_out   = r_mem_valid;
    assign mem_addr_out    = r_mem_addr;
    assign mem_rd_addr_out = r_mem_rd_addr;
    assign mem_w_en_out    = r_mem_w_en;
    assign mem_last_out    = r_mem_last;
    assign mem_tag_out     = r_tag;
    assign done_out        = r_done;
    assign wb_en_out       = r_wb_en;
    assign wb_rn_addr_out  = r_wb_rn;
    assign wb_data_out     = r_wb_data;
    assign wb_tag_out      = r_tag;

endmodule

// File: tb/tb_load_store_multiple_sequencer.sv
// Randomised and directed bench for the LDM/STM sequencer against a
// transaction-level model of the expected beat list and writeback record.
module tb_load_store_multiple_sequencer;

    localparam int ADDR_W = 32;
    localparam int TAG_W  = 4;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              req_valid_in;
    logic              req_ready_out;
    logic              req_load_in;
    logic              req_up_in;
    logic              req_pre_in;
    logic              req_wb_in;
    logic [ADDR_W-1:0] req_base_in;
    logic [3:0]        req_rn_addr_in;
    logic [15:0]       req_reg_list_in;
    logic [TAG_W-1:0]  req_tag_in;
    logic              mem_ready_in;
    logic              mem_valid_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [3:0]        mem_rd_addr_out;
    logic              mem_w_en_out;
    logic              mem_last_out;
    logic [TAG_W-1:0]  mem_tag_out;
    logic              done_out;
    logic              wb_en_out;
    logic [3:0]        wb_rn_addr_out;
    logic [ADDR_W-1:0] wb_data_out;
    logic [TAG_W-1:0]  wb_tag_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    int                exp_idx_q[$];

    always #5 clk_in = ~clk_in;

    load_store_multiple_sequencer #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .req_valid_in    (req_valid_in),
        .req_ready_out   (req_ready_out),
        .req_load_in     (req_load_in),
        .req_up_in       (req_up_in),
        .req_pre_in      (req_pre_in),
        .req_wb_in       (req_wb_in),
        .req_base_in     (req_base_in),
        .req_rn_addr_in  (req_rn_addr_in),
        .req_reg_list_in (req_reg_list_in),
        .req_tag_in      (req_tag_in),
        .mem_ready_in    (mem_ready_in),
        .mem_valid_out   (mem_valid_out),
        .mem_addr_out    (mem_addr_out),
        .mem_rd_addr_out (mem_rd_addr_out),
        .mem_w_en_out    (mem_w_en_out),
        .mem_last_out    (mem_last_out),
        .mem_tag_out     (mem_tag_out),
        .done_out        (done_out),
        .wb_en_out       (wb_en_out),
        .wb_rn_addr_out  (wb_rn_addr_out),
        .wb_data_out     (wb_data_out),
        .wb_tag_out      (wb_tag_out)
    );

    task automatic scramble_req();
        req_load_in     = 1'($urandom);
        req_up_in       = 1'($urandom);
        req_pre_in      = 1'($urandom);
        req_wb_in       = 1'($urandom);
        req_base_in     = $urandom;
        req_rn_addr_in  = 4'($urandom);
        req_reg_list_in = 16'($urandom);
        req_tag_in      = TAG_W'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int budget = 0;
        while (req_ready_out !== 1'b1 && budget < 40) begin
            @(negedge clk_in);
            budget++;
        end
        n_checks++;
        if (req_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL %s idle_timeout ready=%b expected 1", name, req_ready_out);
        end
    endtask

    // Whole transfer: model expectations, issue, follow every beat, check the record.
    task automatic run_request(input bit load, input bit up, input bit pre, input bit wb,
                               input logic [ADDR_W-1:0] base, input logic [3:0] rn,
                               input logic [15:0] list, input logic [TAG_W-1:0] tag,
                               input int stall_first, input bit rand_ready, input string name);
        int n = 0;
        int k = 0;
        int beat = 0;
        int stalled = 0;
        int cycles = 0;
        bit ready;
        logic [ADDR_W-1:0] lowest;
        logic [ADDR_W-1:0] exp_wb_data;
        bit exp_wb_en;

        for (int i = 0; i < 16; i++) if (list[i]) n++;
        if (up) lowest = pre ? base + 32'd4 : base;
        else    lowest = pre ? base - 32'(4 * n) : base - 32'(4 * (n - 1));
        exp_addr_q.delete();
        exp_idx_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_addr_q.push_back(lowest + 32'(4 * k));
                exp_idx_q.push_back(i);
                k++;
            end
        end
        exp_wb_data = up ? base + 32'(4 * n) : base - 32'(4 * n);
        exp_wb_en   = wb && !(load && list[rn]);

        wait_idle(name);
        req_load_in = load; req_up_in = up; req_pre_in = pre; req_wb_in = wb;
        req_base_in = base; req_rn_addr_in = rn; req_reg_list_in = list; req_tag_in = tag;
        req_valid_in = 1'b1;
        mem_ready_in = 1'b0;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        scramble_req();

        while (exp_addr_q.size() > 0 && cycles < 300) begin
            n_checks++;
            if (mem_valid_out !== 1'b1 || done_out !== 1'b0 || req_ready_out !== 1'b0) begin
                n_errors++;
                $display("FAIL %s beat%0d_ctrl valid=%b done=%b ready=%b expected 1/0/0",
                         name, beat, mem_valid_out, done_out, req_ready_out);
            end
            n_checks++;
            if (mem_addr_out !== exp_addr_q[0] || mem_rd_addr_out !== 4'(exp_idx_q[0])) begin
                n_errors++;
                $display("FAIL %s beat%0d_addr got addr=%h reg=%0d expected addr=%h reg=%0d",
                         name, beat, mem_addr_out, mem_rd_addr_out, exp_addr_q[0], exp_idx_q[0]);
            end
            n_checks++;
            if (mem_w_en_out !== !load || mem_last_out !== (exp_addr_q.size() == 1) ||
                mem_tag_out !== tag) begin
                n_errors++;
                $display("FAIL %s beat%0d_flags got w_en=%b last=%b tag=%h expected w_en=%b last=%b tag=%h",
                         name, beat, mem_w_en_out, mem_last_out, mem_tag_out, !load,
                         exp_addr_q.size() == 1, tag);
            end
            if (beat == 0 && stalled < stall_first) ready = 1'b0;
            else if (rand_ready)                    ready = ($urandom_range(0, 3) != 0);
            else                                    ready = 1'b1;
            mem_ready_in = ready;
            if (ready) begin
                void'(exp_addr_q.pop_front());
                void'(exp_idx_q.pop_front());
                beat++;
                stalled = 0;
            end else begin
                stalled++;
            end
            @(negedge clk_in);
            cycles++;
        end
        if (exp_addr_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s beat_timeout remaining=%0d expected 0", name, exp_addr_q.size());
            exp_addr_q.delete();
            exp_idx_q.delete();
        end

        n_checks++;
        if (done_out !== 1'b1 || mem_valid_out !== 1'b0 || req_ready_out !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done_ctrl done=%b valid=%b ready=%b expected 1/0/0",
                     name, done_out, mem_valid_out, req_ready_out);
        end
        n_checks++;
        if (wb_en_out !== exp_wb_en || wb_data_out !== exp_wb_data ||
            wb_rn_addr_out !== rn || wb_tag_out !== tag) begin
            n_errors++;
            $display("FAIL %s wb_record got en=%b data=%h rn=%0d tag=%h expected en=%b data=%h rn=%0d tag=%h",
                     name, wb_en_out, wb_data_out, wb_rn_addr_out, wb_tag_out,
                     exp_wb_en, exp_wb_data, rn, tag);
        end
        // A request offered while DONE must be ignored.
        scramble_req();
        req_reg_list_in = 16'hFFFF;
        req_valid_in = 1'b1;
        mem_ready_in = 1'($urandom);
        @(negedge clk_in);
        n_checks++;
        if (done_out !== 1'b0 || wb_en_out !== 1'b0 || mem_valid_out !== 1'b0 ||
            req_ready_out !== 1'b1) begin
            n_errors++;
            $display("FAIL %s after_done done=%b wb_en=%b valid=%b ready=%b expected 0/0/0/1",
                     name, done_out, wb_en_out, mem_valid_out, req_ready_out);
        end
        req_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        req_valid_in = 1'b1;
        scramble_req();
        mem_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (req_ready_out !== 1'b1 || mem_valid_out !== 1'b0 || done_out !== 1'b0 ||
            wb_en_out !== 1'b0 || mem_addr_out !== '0 || wb_data_out !== '0 ||
            mem_last_out !== 1'b0 || mem_rd_addr_out !== '0) begin
            n_errors++;
            $display("FAIL reset_state ready=%b valid=%b done=%b wb_en=%b addr=%h wb_data=%h expected 1/0/0/0/0/0",
                     req_ready_out, mem_valid_out, done_out, wb_en_out, mem_addr_out, wb_data_out);
        end
        req_valid_in = 1'b0;
        reset_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_directed();
        run_request(1, 1, 0, 1, 32'h0000_1000, 4'd13, 16'h0025, 4'h3, 0, 0, "ldmia");
        run_request(0, 0, 1, 1, 32'h0000_2000, 4'd1, 16'h4010, 4'h7, 0, 0, "stmdb");
        run_request(1, 1, 1, 0, 32'h0000_3000, 4'd2, 16'h0003, 4'h9, 3, 0, "ldmib_stall");
        run_request(1, 1, 0, 1, 32'hFFFF_FFFC, 4'd6, 16'h0003, 4'h1, 0, 0, "wrap");
        run_request(1, 0, 0, 1, 32'h0000_4440, 4'd5, 16'h0000, 4'h5, 0, 0, "empty");
        run_request(1, 1, 0, 1, 32'h0000_5000, 4'd3, 16'h0008, 4'h2, 0, 0, "rn_in_list");
        run_request(0, 0, 0, 1, 32'h0000_6000, 4'd0, 16'hFFFF, 4'hE, 1, 1, "stmda_full");
    endtask

    task automatic test_reset_mid_issue();
        wait_idle("reset_mid");
        req_load_in = 1; req_up_in = 1; req_pre_in = 0; req_wb_in = 1;
        req_base_in = 32'h0000_7000; req_rn_addr_in = 4'd3; req_reg_list_in = 16'h00F0;
        req_tag_in = 4'hA;
        req_valid_in = 1'b1;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        mem_ready_in = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (mem_valid_out !== 1'b1 || mem_rd_addr_out !== 4'd5 || mem_addr_out !== 32'h0000_7004) begin
            n_errors++;
            $display("FAIL reset_mid second_beat valid=%b reg=%0d addr=%h expected 1/5/00007004",
                     mem_valid_out, mem_rd_addr_out, mem_addr_out);
        end
        reset_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (mem_valid_out !== 1'b0 || done_out !== 1'b0 || req_ready_out !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_mid cycle%0d valid=%b done=%b ready=%b expected 0/0/1",
                         c, mem_valid_out, done_out, req_ready_out);
            end
            @(negedge clk_in);
        end
        mem_ready_in = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] list;
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0:       list = 16'h0000;
                1:       list = 16'(1) << $urandom_range(0, 15);
                2:       list = 16'($urandom) & 16'($urandom);
                default: list = 16'($urandom);
            endcase
            run_request(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                        4'($urandom), list, TAG_W'($urandom), $urandom_range(0, 2), 1'b1,
                        $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        reset_in = 1'b0;
        req_valid_in = 1'b0;
        mem_ready_in = 1'b0;
        scramble_req();
        @(negedge clk_in);
        test_reset();
        test_directed();
        test_reset_mid_issue();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
